// File: rtl/uart_rx_if.sv
// RX FIFO write port of the UART receiver: write strobe, data and the FIFO full flag.
interface uart_rx_if;
    logic       wr_en_o;
    logic [7:0] rx_data_o;
    logic       fifo_F_i;

    modport master (output wr_en_o, output rx_data_o, input fifo_F_i);
    modport slave  (input wr_en_o, input rx_data_o, output fifo_F_i);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, LSB-first deserialiser,
// single-cycle FIFO write strobe and sticky framing/overrun status.
module uart_rx #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       baud_tick_i,
    input  logic       rx_en_i,
    input  logic       rx_i,
    input  logic       err_clr_i,
    uart_rx_if.master  fifo_if,
    output logic [2:0] rx_stat_o
);

    localparam int             TW      = $clog2(OVS);
    localparam logic [TW-1:0]  HALF_M1 = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1 = TW'(OVS - 1);
    localparam logic [TW-1:0]  TICK1   = TW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state;
    logic [TW-1:0]          tick_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   armed;
    logic                   overrun;
    logic                   frame_err;
    logic                   busy;

    // Metastability synchroniser; idles high like the line itself.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign rx_stat_o = {overrun, frame_err, busy};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state             <= IDLE;
            tick_cnt          <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            armed             <= 1'b0;
            overrun           <= 1'b0;
            frame_err         <= 1'b0;
            busy              <= 1'b0;
            fifo_if.wr_en_o   <= 1'b0;
            fifo_if.rx_data_o <= '0;
        end else begin
            fifo_if.wr_en_o <= 1'b0;
            // A clear is overridden below by an error event in the same clk.
            if (err_clr_i) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (state != IDLE && !rx_en_i) begin
                state    <= IDLE;
                busy     <= 1'b0;
                armed    <= 1'b0;
                tick_cnt <= '0;
            end else if (baud_tick_i) begin
                case (state)
                    IDLE: begin
                        if (armed && !rx_s && rx_en_i) begin
                            state    <= START;
                            busy     <= 1'b1;
                            tick_cnt <= '0;
                            armed    <= 1'b0;
                        end else if (rx_s) begin
                            armed <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_M1) begin
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_M1) begin
                            shift    <= {rx_s, shift[7:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end else begin
                                // Return at mid-stop-bit so the next start edge is caught.
                                state <= IDLE;
                                busy  <= 1'b0;
                                armed <= 1'b1;
                                if (fifo_if.fifo_F_i) begin
                                    overrun <= 1'b1;
                                end else begin
                                    fifo_if.wr_en_o   <= 1'b1;
                                    fifo_if.rx_data_o <= shift;
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK1;
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            armed <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at OVS=16 with a baud tick every 4 clks.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       baud_tick_i = 1'b0;
    logic       rx_en_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       err_clr_i = 1'b0;
    logic [2:0] rx_stat_o;

    uart_rx_if u_if ();

    uart_rx #(.OVS(16), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .baud_tick_i (baud_tick_i),
        .rx_en_i     (rx_en_i),
        .rx_i        (rx_i),
        .err_clr_i   (err_clr_i),
        .fifo_if     (u_if.master),
        .rx_stat_o   (rx_stat_o)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk_i = ~clk_i;

    initial begin
        forever begin
            repeat (3) @(posedge clk_i);
            #1 baud_tick_i = 1'b1;
            @(posedge clk_i);
            #1 baud_tick_i = 1'b0;
        end
    end

    // Capture every FIFO write; a strobe longer than one clk shows up as an extra byte.
    always @(negedge clk_i) begin
        if (u_if.wr_en_o === 1'b1) got_q.push_back(u_if.rx_data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [7:0] g;
        logic [7:0] e;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, " data"}, 32'(g), 32'(e));
        end
        check({tag, " missing"}, 32'(exp_q.size()), 32'd0);
        check({tag, " extra"}, 32'(got_q.size()), 32'd0);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (BIT_CLKS) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic pulse_clr();
        @(posedge clk_i);
        #1 err_clr_i = 1'b1;
        @(posedge clk_i);
        #1 err_clr_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        logic       saw_busy;
        logic [7:0] c3;
        u_if.fifo_F_i = 1'b0;
        c3 = 8'hC3;

        // Reset state
        #23;
        check("reset wr_en", 32'(u_if.wr_en_o), 32'd0);
        check("reset data", 32'(u_if.rx_data_o), 32'd0);
        check("reset stat", 32'(rx_stat_o), 32'd0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        idle_clks(2 * BIT_CLKS);

        // 1: single good frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle_clks(BIT_CLKS);
        sb_check("t1 A5");
        check("t1 stat", 32'(rx_stat_o), 32'd0);

        // 2: glitch shorter than half a bit
        saw_busy = 1'b0;
        rx_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            saw_busy |= rx_stat_o[0];
        end
        rx_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_i);
            saw_busy |= rx_stat_o[0];
        end
        check("t2 busy pulse", 32'(saw_busy), 32'd1);
        check("t2 stat", 32'(rx_stat_o), 32'd0);
        sb_check("t2 glitch");

        // 3: framing error, break, clear, recovery
        send_frame(8'h3C, 1'b0);
        rx_i = 1'b0;
        idle_clks(2 * BIT_CLKS);
        check("t3 stat in break", 32'(rx_stat_o), 32'b011);
        rx_i = 1'b1;
        idle_clks(BIT_CLKS);
        check("t3 stat after break", 32'(rx_stat_o), 32'b010);
        pulse_clr();
        check("t3 stat cleared", 32'(rx_stat_o), 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle_clks(BIT_CLKS);
        sb_check("t3 55");

        // 4: overrun with FIFO full, then good byte while overrun sticks
        u_if.fifo_F_i = 1'b1;
        send_frame(8'h81, 1'b1);
        idle_clks(BIT_CLKS);
        check("t4 overrun stat", 32'(rx_stat_o), 32'b100);
        sb_check("t4 81 dropped");
        u_if.fifo_F_i = 1'b0;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle_clks(BIT_CLKS);
        check("t4 overrun sticky", 32'(rx_stat_o), 32'b100);
        sb_check("t4 7E");
        pulse_clr();
        check("t4 stat cleared", 32'(rx_stat_o), 32'd0);

        // 5: back-to-back frames, single stop bit between
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_clks(BIT_CLKS);
        sb_check("t5 00 FF");
        check("t5 stat", 32'(rx_stat_o), 32'd0);
        check("t5 last data", 32'(u_if.rx_data_o), 32'hFF);

        // 6a: rx_en_i dropped after bit 3
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(c3[i]);
        rx_i = c3[4];
        idle_clks(20);
        check("t6 busy mid frame", 32'(rx_stat_o), 32'b001);
        @(posedge clk_i);
        #1 rx_en_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("t6 abort stat", 32'(rx_stat_o), 32'd0);
        idle_clks(3 * BIT_CLKS);
        rx_i = 1'b1;
        idle_clks(2 * BIT_CLKS);
        rx_en_i = 1'b1;
        idle_clks(BIT_CLKS);
        check("t6 stat after abort", 32'(rx_stat_o), 32'd0);
        sb_check("t6 abort");

        // 6b: asynchronous reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(c3[i]);
        check("t6 busy before rst", 32'(rx_stat_o), 32'b001);
        @(posedge clk_i);
        #3 rstn_i = 1'b0;
        #1;
        check("t6 rst wr_en", 32'(u_if.wr_en_o), 32'd0);
        check("t6 rst data", 32'(u_if.rx_data_o), 32'd0);
        check("t6 rst stat", 32'(rx_stat_o), 32'd0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        idle_clks(2 * BIT_CLKS);
        sb_check("t6 no write after rst");
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle_clks(BIT_CLKS);
        sb_check("t6 5A after rst");
        check("t6 final stat", 32'(rx_stat_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the APB UART slave. It is the receive-side counterpart of the existing TX path. It oversamples the serial line using a baud-tick enable and deserialises 8N1 frames, LSB first. Good bytes are written into the RX FIFO with a single-cycle write strobe. Framing and overrun errors are reported as sticky status bits to the CTRL/STATUS register block. Everything runs in the bus clock domain.

Parameters:
OVS, 16, baud_tick_i pulses per bit period; must be even and at least 8.
SYNC_STAGES, 2, number of flops in the rx_i synchroniser; minimum 2.

Ports:
clk_i  in  1  bus clock; the block's only clock.
rstn_i  in  1  asynchronous, active-low reset.
baud_tick_i  in  1  one-clk pulse at OVS times the baud rate.
rx_en_i  in  1  RX enable from the CTRL register.
rx_i  in  1  serial input line, asynchronous, idles high.
fifo_F_i  in  1  RX FIFO full flag.
err_clr_i  in  1  one-clk pulse; clears both sticky error bits.
wr_en_o  out  1  RX FIFO write strobe, asserted for one clk.
rx_data_o  out  8  received byte; valid whenever wr_en_o=1.
rx_stat_o  out  3  status as {overrun, frame_err, busy}.

Behaviour:
- Reset values: wr_en_o=0, rx_data_o=0, rx_stat_o=000, state=IDLE, bit and tick counters 0, armed=0, synchroniser flops all 1.
- rx_i passes through SYNC_STAGES flops to form rx_s. All sampling uses rx_s.
- Counters advance only on clks where baud_tick_i=1. The exception is the rx_en_i abort, which acts on any clk.
- tick_cnt is log2(OVS) bits wide. bit_cnt is 3 bits wide. shift is an 8-bit register that shifts right, with the new bit entering at [7].
- State IDLE:
  - On a tick with rx_s=1, set armed=1.
  - On a tick with armed=1, rx_s=0 and rx_en_i=1: go to START, set tick_cnt=0, set armed=0.
  - A line that is low at enable time or after reset is never taken as a start bit until it has been seen high.
- State START, on each tick:
  - If tick_cnt==OVS/2-1, sample rx_s. If rx_s=1 the event is a glitch: return to IDLE with no write and no error. If rx_s=0: set tick_cnt=0, bit_cnt=0, go to DATA.
  - Otherwise tick_cnt+1.
- State DATA, on each tick:
  - If tick_cnt==OVS-1: shift <= {rx_s, shift[7:1]}, tick_cnt=0. If bit_cnt==7 go to STOP, else bit_cnt+1.
  - Otherwise tick_cnt+1.
- State STOP, sample rx_s on the tick where tick_cnt==OVS-1:
  - rx_s=1 and fifo_F_i=0: on the next clk, wr_en_o=1 for exactly one clk and rx_data_o=shift. Go to IDLE with armed=1.
  - rx_s=1 and fifo_F_i=1: no write; set overrun=1; go to IDLE with armed=1. The byte is discarded.
  - rx_s=0: no write; set frame_err=1; go to BREAK.
  - IDLE is entered at mid-stop-bit, so a following start edge half a bit later is caught.
- State BREAK: stay until a tick with rx_s=1, then go to IDLE with armed=1.
- rx_data_o holds its value between writes.
- Latency: wr_en_o rises one clk after the stop-sample tick. rx_i to rx_s adds SYNC_STAGES clks.
- rx_en_i=0 while in START, DATA, STOP or BREAK: on the next clk go to IDLE, armed=0, no write, no error flagged. A frame already in flight is lost.
- Sticky errors:
  - overrun and frame_err stay set until err_clr_i.
  - If err_clr_i and a new error event land in the same clk, the bit ends up set.
  - err_clr_i has no effect on state.
- busy = (state != IDLE), registered.
- Asserting rstn_i mid-frame forces the full reset state immediately. No partial write may occur.

Test Plan:
1. OVS=16, baud_tick_i every 4 clks. Drive 0xA5, 8N1, stop=1, fifo_F_i=0 -> exactly one wr_en_o pulse with rx_data_o=0xA5; rx_stat_o returns to 000 after the stop bit.
2. Glitch: rx_i low for 4 ticks, then high -> no wr_en_o; busy pulses then clears; no error bits set.
3. Framing error: 0x3C with stop bit 0, line held low for 2 more bit times, then high -> no write; frame_err=1; busy stays 1 until the line goes high. Then pulse err_clr_i -> rx_stat_o=000. Next frame 0x55 is written correctly.
4. Overrun: fifo_F_i=1 while 0x81 is received -> no write, overrun=1. Drop fifo_F_i and send 0x7E -> written as 0x7E with overrun still 1.
5. Back-to-back 0x00 then 0xFF with a single stop bit between them -> two writes, 0x00 then 0xFF, no errors.
6. rx_en_i deasserted after bit 3 of 0xC3 -> IDLE within 1 clk, no write, no error. Separately, rstn_i low mid-frame -> all outputs at reset values immediately.
